div_controller: RTL and testbench

Sequencing FSM for the 10-bit sequential restoring divider. Sits directly upstream of the Q shift register (dividend/quotient register) and the A (partial remainder) and B (divisor) registers, driving their load/shift/serial-in controls. It consumes status from the datapath subtractor and provides a start/done handshake to the surrounding system. One quotient bit is produced per cycle.

---
 rtl/div_controller.sv | 156 +++++++++++++++
 tb/tb_div_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_controller.sv
// div_controller
//   Sequencing FSM for an N-bit sequential restoring divider. Drives the
//   load/shift/serial-in controls of the Q (dividend/quotient), A (partial
//   remainder) and B (divisor) registers. It produces one quotient bit per
//   ITER cycle and offers a start/busy/done handshake.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active low
//   start    : division request, sampled only in IDLE
//   borrow   : datapath flag, trial {A[N-2:0],Q[N-1]} - B is negative
//   b_zero   : datapath flag, B == 0
//   ldB      : load divisor register B
//   ldQ      : parallel-load Q with the dividend
//   shQ      : shift Q left one bit
//   serQ     : bit shifted into Q LSB (new quotient bit)
//   clrA     : clear A
//   shA      : A <= {A[N-2:0],Q[N-1]} (restore path)
//   ldA_diff : A <= subtractor result (subtract path)
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse, quotient in Q and remainder in A
//   dz_err   : divide-by-zero flag, held until the next LOAD

module div_controller #(
  parameter int unsigned N  = 10,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic borrow,
  input  logic b_zero,
  output logic ldB,
  output logic ldQ,
  output logic shQ,
  output logic serQ,
  output logic clrA,
  output logic shA,
  output logic ldA_diff,
  output logic busy,
  output logic done,
  output logic dz_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ITER,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_err_q, dz_err_d;

  // Moore outputs are registered from the next state so they change only
  // on the clock edge together with the state itself.
  logic ld_b_q, ld_b_d;
  logic ld_q_q, ld_q_d;
  logic clr_a_q, clr_a_d;
  logic sh_q_q, sh_q_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic last_iter;
  assign last_iter = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dz_err_d = dz_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d    = '0;
        dz_err_d = 1'b0;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (b_zero) begin
          dz_err_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ld_b_d  = (state_d == S_LOAD);
    ld_q_d  = (state_d == S_LOAD);
    clr_a_d = (state_d == S_LOAD);
    sh_q_d  = (state_d == S_ITER);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dz_err_q <= 1'b0;
      ld_b_q   <= 1'b0;
      ld_q_q   <= 1'b0;
      clr_a_q  <= 1'b0;
      sh_q_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dz_err_q <= dz_err_d;
      ld_b_q   <= ld_b_d;
      ld_q_q   <= ld_q_d;
      clr_a_q  <= clr_a_d;
      sh_q_q   <= sh_q_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Mealy outputs: the quotient bit and the A update path follow the
  // combinational borrow flag, qualified by the ITER state.
  logic in_iter;
  assign in_iter = (state_q == S_ITER);

  assign serQ     = in_iter & ~borrow;
  assign shA      = in_iter &  borrow;
  assign ldA_diff = in_iter & ~borrow;

  assign ldB    = ld_b_q;
  assign ldQ    = ld_q_q;
  assign clrA   = clr_a_q;
  assign shQ    = sh_q_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign dz_err = dz_err_q;

endmodule

// File: tb/tb_div_controller.sv
// tb_div_controller
//   Bench for div_controller with a behavioural A/B/Q datapath attached.
//   Stimulus pushes hand-computed expectations into a queue; a monitor pops
//   and compares whenever done pulses.

module tb_div_controller;

  localparam int unsigned N = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic borrow, b_zero;
  logic ldB, ldQ, shQ, serQ, clrA, shA, ldA_diff, busy, done, dz_err;

  always #5 clk = ~clk;

  div_controller #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .borrow(borrow), .b_zero(b_zero),
    .ldB(ldB), .ldQ(ldQ), .shQ(shQ), .serQ(serQ), .clrA(clrA), .shA(shA),
    .ldA_diff(ldA_diff), .busy(busy), .done(done), .dz_err(dz_err)
  );

  // Behavioural datapath
  logic [N-1:0] a_r = '0, b_r = '0, q_r = '0;
  logic [N-1:0] dividend_in = '0, divisor_in = '0;
  logic [N-1:0] trial;
  assign trial  = {a_r[N-2:0], q_r[N-1]};
  assign borrow = (trial < b_r);
  assign b_zero = (b_r == '0);

  always @(posedge clk) begin
    if (ldB) b_r <= divisor_in;
    if (ldQ) q_r <= dividend_in;
    else if (shQ) q_r <= {q_r[N-2:0], serQ};
    if (clrA) a_r <= '0;
    else if (ldA_diff) a_r <= trial - b_r;
    else if (shA) a_r <= trial;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    string name;
    int    exp_q;
    int    exp_a;
    int    exp_dz;
    int    exp_lat;
    int    exp_shq;
    int    exp_diffs;
  } exp_t;

  exp_t sb_q[$];

  // Monitor
  bit           active = 0;
  int           t_start = 0, shq_cnt = 0, diff_cnt = 0, excl_bad = 0;
  logic [N-1:0] ser_seq = '0;

  always @(negedge clk) begin
    exp_t e;
    if (shA && ldA_diff) excl_bad++;
    if (ldQ && shQ) excl_bad++;
    if (active) begin
      if (shQ) begin
        shq_cnt++;
        ser_seq = {ser_seq[N-2:0], serQ};
      end
      if (ldA_diff) diff_cnt++;
      if (cyc == t_start + 2) chk("dz_clear_in_check", int'(dz_err), 0);
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_latency"}, cyc - t_start, e.exp_lat);
        chk({e.name, "_quotient"}, int'(q_r), e.exp_q);
        chk({e.name, "_remainder"}, int'(a_r), e.exp_a);
        chk({e.name, "_dz_err"}, int'(dz_err), e.exp_dz);
        chk({e.name, "_shq_pulses"}, shq_cnt, e.exp_shq);
        chk({e.name, "_subtracts"}, diff_cnt, e.exp_diffs);
        chk({e.name, "_serq_seq"}, int'(ser_seq), e.exp_dz != 0 ? 0 : e.exp_q);
        chk({e.name, "_busy_at_done"}, int'(busy), 1);
        chk({e.name, "_exclusive_strobes"}, excl_bad, 0);
      end
      active = 0;
    end
    if (start && !busy && rst) begin
      active   = 1;
      t_start  = cyc;
      shq_cnt  = 0;
      diff_cnt = 0;
      ser_seq  = '0;
    end
    if (!rst) active = 0;
  end

  function automatic int all_strobes();
    return int'({ldB, ldQ, shQ, serQ, clrA, shA, ldA_diff, busy, done});
  endfunction

  task automatic wait_sb(input int target, input string name, input bit pulse_iter);
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (pulse_iter && k == 4) start = 1'b1;
      if (pulse_iter && k == 6) start = 1'b0;
      if (sb_q.size() <= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk({name, "_timeout"}, 0, 1);
      sb_q.delete();
    end
  endtask

  task automatic run_op(input string name, input int dvd, input int dvs,
                        input int eq, input int ea, input int edz, input int elat,
                        input int eshq, input int ediffs, input bit pulse_iter);
    exp_t e;
    e.name = name; e.exp_q = eq; e.exp_a = ea; e.exp_dz = edz;
    e.exp_lat = elat; e.exp_shq = eshq; e.exp_diffs = ediffs;
    sb_q.push_back(e);
    dividend_in = N'(dvd);
    divisor_in  = N'(dvs);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_sb(0, name, pulse_iter);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int d1, d2, d3;

    // Reset with start held high
    rst = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", all_strobes(), 0);
    chk("reset_dz_err", int'(dz_err), 0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_reset", all_strobes(), 0);

    run_op("div_100_7", 100, 7, 14, 2, 0, 13, 10, 3, 0);
    run_op("div_1023_1", 1023, 1, 1023, 0, 0, 13, 10, 10, 0);
    run_op("div_5_9", 5, 9, 0, 5, 0, 13, 10, 0, 0);
    run_op("div_37_0", 37, 0, 37, 0, 1, 3, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("dz_err_held_in_idle", int'(dz_err), 1);
    run_op("div_20_4", 20, 4, 5, 0, 0, 13, 10, 2, 0);
    run_op("div_100_7_pulse", 100, 7, 14, 2, 0, 13, 10, 3, 1);

    // Reset during the 5th ITER cycle (cycle t+7)
    e.name = "aborted"; e.exp_q = 0; e.exp_a = 0; e.exp_dz = 0;
    e.exp_lat = 0; e.exp_shq = 0; e.exp_diffs = 0;
    sb_q.push_back(e);
    dividend_in = 10'd100;
    divisor_in  = 10'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("iter5_shq_active", int'(shQ), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midop_reset_strobes", all_strobes(), 0);
    rst = 1'b1;
    sb_q.delete();
    repeat (15) @(posedge clk);
    #1;
    run_op("div_100_7_after_abort", 100, 7, 14, 2, 0, 13, 10, 3, 0);

    // start held high: back-to-back relaunches every 14 cycles
    e.exp_dz = 0; e.exp_lat = 13; e.exp_shq = 10;
    e.name = "held_100_7";  e.exp_q = 14;   e.exp_a = 2; e.exp_diffs = 3;  sb_q.push_back(e);
    e.name = "held_1023_1"; e.exp_q = 1023; e.exp_a = 0; e.exp_diffs = 10; sb_q.push_back(e);
    e.name = "held_5_9";    e.exp_q = 0;    e.exp_a = 5; e.exp_diffs = 0;  sb_q.push_back(e);
    dividend_in = 10'd100;
    divisor_in  = 10'd7;
    start = 1'b1;
    wait_sb(2, "held_run1", 0);
    d1 = cyc;
    @(posedge clk);
    #1 dividend_in = 10'd1023;
    divisor_in = 10'd1;
    wait_sb(1, "held_run2", 0);
    d2 = cyc;
    @(posedge clk);
    #1 dividend_in = 10'd5;
    divisor_in = 10'd9;
    wait_sb(0, "held_run3", 0);
    d3 = cyc;
    start = 1'b0;
    chk("held_spacing_1", d2 - d1, 14);
    chk("held_spacing_2", d3 - d2, 14);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_at_end", all_strobes(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
